id_ex_reg: RTL

ID_EX_REG -- requirements
Module: id_ex_reg

---
 rtl/riscv_pkg.sv | 39 +++
 rtl/hazard_detect.sv | 20 ++
 rtl/id_ex_reg.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared decode definitions for the RV64 pipeline.
//   ctrl_t    : 8-bit control bundle {MemRead, MemtoReg, MemWrite, RegWrite,
//               Branch, ALUSrc, ALUop[1:0]}, MSB first.
//   CTRL_*    : bit positions of each field inside the bundle.
//   ALUOP_*   : ALUop encodings produced by the decoder.
//   OPC_*     : major opcode constants recognised by the decoder.
package riscv_pkg;

   typedef struct packed {
      logic       mem_read;
      logic       mem_to_reg;
      logic       mem_write;
      logic       reg_write;
      logic       branch;
      logic       alu_src;
      logic [1:0] alu_op;
   } ctrl_t;

   localparam int CTRL_W          = 8;
   localparam int CTRL_MEM_READ   = 7;
   localparam int CTRL_MEM_TO_REG = 6;
   localparam int CTRL_MEM_WRITE  = 5;
   localparam int CTRL_REG_WRITE  = 4;
   localparam int CTRL_BRANCH     = 3;
   localparam int CTRL_ALU_SRC    = 2;
   localparam int CTRL_ALU_OP_HI  = 1;
   localparam int CTRL_ALU_OP_LO  = 0;

   localparam logic [1:0] ALUOP_ADD    = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

   localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
   localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use hazard detection.
//   ex_valid, ex_mem_read, ex_rd : instruction currently held in EX.
//   id_rs1, id_rs2               : source registers of the instruction in ID.
//   hazard                       : 1 when ID reads the register a load in EX
//                                  is about to write (x0 never counts).
module hazard_detect (
   input  logic       ex_valid,
   input  logic       ex_mem_read,
   input  logic [4:0] ex_rd,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   output logic       hazard
);

   always_comb begin
      hazard = ex_valid & ex_mem_read & (ex_rd != 5'd0) &
               ((ex_rd == id_rs1) | (ex_rd == id_rs2));
   end

endmodule

// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register with load-use stall control.
//   Inputs : clk, rst_n (async, active-low), id_* decode-stage fields,
//            ext_stall (hold), flush (squash into a bubble).
//   Outputs: ex_* registered fields + ex_valid, control_sel (zero decoder
//            outputs), pc_write / if_id_write (front-end enables),
//            stall_cnt (saturating count of load-use stall cycles).
//   Per-edge priority: flush > ext_stall > capture.
module id_ex_reg #(
   parameter int XLEN = 64,
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [7:0]      id_ctrl,
   input  logic [XLEN-1:0] id_pc,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic [XLEN-1:0] id_imm,
   input  logic [4:0]      id_rs1,
   input  logic [4:0]      id_rs2,
   input  logic [4:0]      id_rd,
   input  logic [3:0]      id_funct,
   input  logic            ext_stall,
   input  logic            flush,
   output logic            control_sel,
   output logic            pc_write,
   output logic            if_id_write,
   output logic [7:0]      ex_ctrl,
   output logic [XLEN-1:0] ex_pc,
   output logic [XLEN-1:0] ex_rs1_data,
   output logic [XLEN-1:0] ex_rs2_data,
   output logic [XLEN-1:0] ex_imm,
   output logic [4:0]      ex_rs1,
   output logic [4:0]      ex_rs2,
   output logic [4:0]      ex_rd,
   output logic [3:0]      ex_funct,
   output logic            ex_valid,
   output logic [CNTW-1:0] stall_cnt
);
   import riscv_pkg::*;

   logic [7:0]      ctrl_q,     ctrl_d;
   logic [XLEN-1:0] pc_q,       pc_d;
   logic [XLEN-1:0] rs1_data_q, rs1_data_d;
   logic [XLEN-1:0] rs2_data_q, rs2_data_d;
   logic [XLEN-1:0] imm_q,      imm_d;
   logic [4:0]      rs1_q,      rs1_d;
   logic [4:0]      rs2_q,      rs2_d;
   logic [4:0]      rd_q,       rd_d;
   logic [3:0]      funct_q,    funct_d;
   logic            valid_q,    valid_d;
   logic [CNTW-1:0] cnt_q,      cnt_d;
   logic            hazard;
   ctrl_t           ex_ctrl_s;

   function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
      return (&v) ? v : v + CNTW'(1);
   endfunction

   assign ex_ctrl_s = ctrl_t'(ctrl_q);

   hazard_detect u_hazard_detect (
      .ex_valid    (valid_q),
      .ex_mem_read (ex_ctrl_s.mem_read),
      .ex_rd       (rd_q),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .hazard      (hazard)
   );

   assign control_sel = hazard;
   assign pc_write    = ~(hazard | ext_stall);
   assign if_id_write = ~(hazard | ext_stall);

   always_comb begin
      ctrl_d     = ctrl_q;
      pc_d       = pc_q;
      rs1_data_d = rs1_data_q;
      rs2_data_d = rs2_data_q;
      imm_d      = imm_q;
      rs1_d      = rs1_q;
      rs2_d      = rs2_q;
      rd_d       = rd_q;
      funct_d    = funct_q;
      valid_d    = valid_q;
      cnt_d      = cnt_q;
      if (flush) begin
         ctrl_d     = '0;
         pc_d       = '0;
         rs1_data_d = '0;
         rs2_data_d = '0;
         imm_d      = '0;
         rs1_d      = '0;
         rs2_d      = '0;
         rd_d       = '0;
         funct_d    = '0;
         valid_d    = 1'b0;
      end else if (!ext_stall) begin
         // On a hazard the operands are still captured, but the control
         // bundle is zeroed here even if the decoder ignored control_sel,
         // and ex_valid drops so the hazard clears after one bubble.
         ctrl_d     = hazard ? 8'h00 : id_ctrl;
         pc_d       = id_pc;
         rs1_data_d = id_rs1_data;
         rs2_data_d = id_rs2_data;
         imm_d      = id_imm;
         rs1_d      = id_rs1;
         rs2_d      = id_rs2;
         rd_d       = id_rd;
         funct_d    = id_funct;
         valid_d    = ~hazard;
         if (hazard) cnt_d = sat_inc(cnt_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q     <= '0;
         pc_q       <= '0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         imm_q      <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         rd_q       <= '0;
         funct_q    <= '0;
         valid_q    <= 1'b0;
         cnt_q      <= '0;
      end else begin
         ctrl_q     <= ctrl_d;
         pc_q       <= pc_d;
         rs1_data_q <= rs1_data_d;
         rs2_data_q <= rs2_data_d;
         imm_q      <= imm_d;
         rs1_q      <= rs1_d;
         rs2_q      <= rs2_d;
         rd_q       <= rd_d;
         funct_q    <= funct_d;
         valid_q    <= valid_d;
         cnt_q      <= cnt_d;
      end
   end

   assign ex_ctrl     = ctrl_q;
   assign ex_pc       = pc_q;
   assign ex_rs1_data = rs1_data_q;
   assign ex_rs2_data = rs2_data_q;
   assign ex_imm      = imm_q;
   assign ex_rs1      = rs1_q;
   assign ex_rs2      = rs2_q;
   assign ex_rd       = rd_q;
   assign ex_funct    = funct_q;
   assign ex_valid    = valid_q;
   assign stall_cnt   = cnt_q;

endmodule
